line_buffer_ctrl: RTL and testbench
===================================

# line_buffer_ctrl

Frame sequencer for the 3x3 window datapath built on the two-line FIFO buffer. It accepts a raster pixel stream, gates the line buffer write enable, and tracks row/column position. It flags when the three line-buffer taps plus the downstream window shift registers hold a complete 3x3 neighbourhood. It sits between the pixel source and the line buffer / Sobel window stage, and owns frame start, frame end and the done handshake.

## Interface

- IMG_W, 640: pixels per line (≥3)
- IMG_H, 480: lines per frame (≥3)
- CW, 10: column counter width, ≥ clog2(IMG_W)
- RW, 9: row counter width, ≥ clog2(IMG_H)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  pulse: arm for one frame; honoured only in IDLE
- valid_i  in  1  pixel present on the source bus this cycle
- ready_o  out  1  controller accepts pixels (FILL or RUN)
- lb_we_o  out  1  line buffer write enable = valid_i & ready_o (combinational)
- win_shift_o  out  1  window shift-register enable, same as lb_we_o
- win_valid_o  out  1  registered: 3x3 window complete for the last accepted pixel
- col_o  out  CW  registered column of the last accepted pixel
- row_o  out  RW  registered row of the last accepted pixel
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse: frame complete

## Operation

- States: IDLE, FILL, RUN, DONE.
- IDLE: ready_o=0. A start_i pulse clears the counters and moves to FILL. valid_i is ignored.
- Accepted pixel: valid_i=1 while ready_o=1. Only accepted pixels advance the counters.
- Column and row counters:
  - col_cnt increments per accepted pixel and wraps IMG_W-1→0.
  - On wrap, row_cnt increments.
  - col_o/row_o load the pre-increment col_cnt/row_cnt value on each accepted pixel.
- FILL→RUN: on the accepted pixel with row_cnt==1 and col_cnt==IMG_W-1. From then on, both line buffers hold full lines.
- RUN→DONE: on the accepted pixel with row_cnt==IMG_H-1 and col_cnt==IMG_W-1. That pixel is still written.
- DONE: lasts one cycle. done_o=1, ready_o=0. Then IDLE.
- win_valid_o:
  - Next cycle after an accepted pixel, it is 1 iff that pixel's row≥2 and col≥2; otherwise 0.
  - It holds 0 on cycles with no accepted pixel.
  - Window count per frame = (IMG_W-2)(IMG_H-2).
- start_i outside IDLE is ignored, including the DONE cycle.
- No stall output toward the source. Gaps in valid_i are permitted anywhere. Counters and state freeze during gaps.

## Timing

- Reset (rst=0, asynchronous) forces:
  - state=IDLE
  - ready_o=0, lb_we_o=0, win_shift_o=0
  - win_valid_o=0, busy_o=0, done_o=0
  - col_o=0, row_o=0, and both counters cleared
- Reset mid-frame abandons the frame; no done_o is issued. The line buffer contents are not cleared by this block.
- start_i sampled at edge N → ready_o=1 and busy_o=1 from cycle N+1.
- lb_we_o/win_shift_o: zero latency from valid_i.
- col_o/row_o/win_valid_o: one cycle after the accepted pixel.
- Last pixel accepted at edge N:
  - state=DONE and done_o=1 during cycle N+1.
  - win_valid_o=1 during cycle N+1 for the last window.
  - IDLE from N+2.
  - Earliest next start_i is sampled at edge N+2.
- Counter arithmetic is unsigned with no overflow. Wrap compares use IMG_W-1/IMG_H-1 exactly, not power-of-two rollover.

## Test plan

- Reset check: assert reset while busy in RUN at row 2, col 3 → all outputs 0 immediately (asynchronous); a new start_i after release restarts at row 0, col 0.
- Back-to-back frame: IMG_W=8, IMG_H=4, start_i, 32 consecutive valid_i → lb_we_o high for exactly 32 cycles, win_valid_o high 12 times, first at (row 2, col 2), last at (3,7); done_o one cycle after the 32nd pixel.
- Bubbles: same frame with valid_i toggling 1,0 → 32 writes over 63 cycles, same 12 windows at the same coordinates, counters frozen during gaps.
- State boundary: ready_o=0 and lb_we_o=0 for valid_i before start_i and in the DONE cycle; FILL→RUN observed after pixel 16 (row 1, col 7).
- Ignored start: start_i pulsed mid-frame and in the DONE cycle → no counter reset, exactly one done_o.
- Minimum size: IMG_W=3, IMG_H=3, 9 pixels → exactly one win_valid_o, at (2,2), coincident with done_o.

Source files
------------

// File: rtl/line_buffer_ctrl.sv
// Frame sequencer for the 3x3 window datapath: gates line buffer writes,
// tracks raster position and flags when a full 3x3 neighbourhood is available.
module line_buffer_ctrl #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10,
    parameter int RW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic          valid_i,
    output logic          ready_o,
    output logic          lb_we_o,
    output logic          win_shift_o,
    output logic          win_valid_o,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [1:0]    state_o
);

    // Handshake: a pixel is accepted on a rising edge where valid_i && ready_o;
    // the source never stalls, so ready_o only reflects whether a frame is open.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          accept;
    logic          arm;
    logic          line_end;
    logic          frame_end;
    logic          fill_end;

    assign accept    = valid_i & ready_o;
    assign arm       = (state_q == IDLE) & start_i;
    assign line_end  = (col_cnt == COL_LAST);
    assign frame_end = line_end & (row_cnt == ROW_LAST);
    // Two full lines are buffered once row 1 has been completely written.
    assign fill_end  = line_end & (row_cnt == ROW_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ready_o     = 1'b0;
        done_o      = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                ready_o = 1'b1;
                if (accept && fill_end) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                ready_o = 1'b1;
                if (accept && frame_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign lb_we_o     = accept;
    assign win_shift_o = accept;
    assign state_o     = state_q;

    // Position counters; cleared on arm and again after the last pixel so
    // row_cnt never has to represent IMG_H.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (arm) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (frame_end) begin
                col_cnt <= '0;
                row_cnt <= '0;
            end else if (line_end) begin
                col_cnt <= '0;
                row_cnt <= row_cnt + ROW_ONE;
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_o       <= '0;
            row_o       <= '0;
            win_valid_o <= 1'b0;
        end else if (accept) begin
            col_o       <= col_cnt;
            row_o       <= row_cnt;
            win_valid_o <= (row_cnt >= ROW_TWO) && (col_cnt >= COL_TWO);
        end else begin
            win_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: an 8x4 instance under randomized and directed
// frames against a position model, plus a 3x3 minimum-size instance.
module tb_line_buffer_ctrl;

  localparam int W = 8;
  localparam int H = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, valid_a = 1'b0;
  logic       ready_a, we_a, shift_a, wv_a, busy_a, done_a;
  logic [2:0] col_a;
  logic [1:0] row_a, state_a;

  logic       start_b = 1'b0, valid_b = 1'b0;
  logic       ready_b, we_b, shift_b, wv_b, busy_b, done_b;
  logic [1:0] col_b, row_b, state_b;

  line_buffer_ctrl #(.IMG_W(W), .IMG_H(H), .CW(3), .RW(2)) dut_a (
    .clk(clk), .rst(rst), .start_i(start_a), .valid_i(valid_a),
    .ready_o(ready_a), .lb_we_o(we_a), .win_shift_o(shift_a),
    .win_valid_o(wv_a), .col_o(col_a), .row_o(row_a), .busy_o(busy_a),
    .done_o(done_a), .state_o(state_a)
  );

  line_buffer_ctrl #(.IMG_W(3), .IMG_H(3), .CW(2), .RW(2)) dut_b (
    .clk(clk), .rst(rst), .start_i(start_b), .valid_i(valid_b),
    .ready_o(ready_b), .lb_we_o(we_b), .win_shift_o(shift_b),
    .win_valid_o(wv_b), .col_o(col_b), .row_o(row_b), .busy_o(busy_b),
    .done_o(done_b), .state_o(state_b)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [4:0] exp_q[$];

  // model: a frame is open from arm until its W*H-th pixel, then one DONE cycle
  bit         m_active = 0;
  bit         m_done = 0;
  int         m_k = 0;
  logic [2:0] e_col = '0;
  logic [1:0] e_row = '0;
  bit         e_win = 0;

  int we_cnt, win_cnt, done_cnt, cyc, first_we, last_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: one clock of dut_a with a check on both sides of the edge
  task automatic cycle_a(input bit st, input bit v);
    bit was_idle;
    bit exp_we;
    int r, c;
    @(negedge clk);
    start_a = st;
    valid_a = v;
    #1;
    exp_we = v && m_active;
    chk("ready", 32'(ready_a), 32'(m_active));
    chk("lb_we", 32'(we_a), 32'(exp_we));
    chk("win_shift", 32'(shift_a), 32'(exp_we));
    if (we_a) begin
      if (first_we < 0) first_we = cyc;
      last_we = cyc;
    end
    @(posedge clk);
    was_idle = !m_active && !m_done;
    e_win = 0;
    if (m_done) begin
      m_done = 0;
    end else if (exp_we) begin
      r = m_k / W;
      c = m_k % W;
      e_row = 2'(r);
      e_col = 3'(c);
      if (r >= 2 && c >= 2) begin
        e_win = 1;
        exp_q.push_back({e_row, e_col});
      end
      m_k++;
      we_cnt++;
      if (m_k == W * H) begin
        m_active = 0;
        m_done = 1;
      end
    end else if (was_idle && st) begin
      m_active = 1;
      m_k = 0;
    end
    #1;
    cyc++;
    chk("win_valid", 32'(wv_a), 32'(e_win));
    chk("col", 32'(col_a), 32'(e_col));
    chk("row", 32'(row_a), 32'(e_row));
    chk("done", 32'(done_a), 32'(m_done));
    chk("busy", 32'(busy_a), 32'(m_active || m_done));
    if (exp_we && m_k == 2 * W - 1) chk("state_fill", 32'(state_a), 32'd1);
    if (exp_we && m_k == 2 * W) chk("state_run", 32'(state_a), 32'd2);
    if (wv_a) begin
      win_cnt++;
      if (exp_q.size() > 0) chk("win_coord", 32'({row_a, col_a}), 32'(exp_q.pop_front()));
    end
    if (done_a) done_cnt++;
  endtask

  // mode 0: contiguous, 1: valid toggles 1,0, 2: random gaps
  task automatic run_frame(input int mode, input bit noisy_start);
    int budget;
    bit v;
    we_cnt = 0; win_cnt = 0; done_cnt = 0; cyc = 0; first_we = -1; last_we = -1;
    cycle_a(1'b1, 1'($urandom_range(0, 1)));
    budget = 0;
    while (m_active && budget < 2000) begin
      case (mode)
        0: v = 1'b1;
        1: v = (budget % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      cycle_a(noisy_start && ($urandom_range(0, 5) == 0), v);
      budget++;
    end
    chk("frame_timeout", 32'(m_active), 32'd0);
    cycle_a(noisy_start, 1'b1);
    cycle_a(1'b0, 1'b0);
    chk("we_count", 32'(we_cnt), 32'(W * H));
    chk("win_count", 32'(win_cnt), 32'((W - 2) * (H - 2)));
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("win_q_left", 32'(exp_q.size()), 32'd0);
    if (mode == 1) chk("write_span", 32'(last_we - first_we + 1), 32'(2 * W * H - 1));
  endtask

  int wins_b;

  initial begin
    #2;
    chk("rst_ready", 32'(ready_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_col", 32'(col_a), 32'd0);
    chk("rst_row", 32'(row_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // valid before start is refused
    cycle_a(1'b0, 1'b1);
    cycle_a(1'b0, 1'b1);

    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(2, 1'b1);
    run_frame(2, 1'b0);

    // asynchronous reset in RUN just after pixel (2,3)
    cycle_a(1'b1, 1'b0);
    while (m_k < 2 * W + 4) cycle_a(1'b0, 1'($urandom_range(0, 1)));
    @(negedge clk);
    valid_a = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ready", 32'(ready_a), 32'd0);
    chk("arst_lb_we", 32'(we_a), 32'd0);
    chk("arst_shift", 32'(shift_a), 32'd0);
    chk("arst_win", 32'(wv_a), 32'd0);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_done", 32'(done_a), 32'd0);
    chk("arst_col", 32'(col_a), 32'd0);
    chk("arst_row", 32'(row_a), 32'd0);
    m_active = 0; m_done = 0; m_k = 0; e_col = '0; e_row = '0;
    exp_q.delete();
    #1;
    rst = 1'b1;
    run_frame(2, 1'b1);

    // minimum size instance: 3x3 frame gives one window with done_o
    wins_b = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    valid_b = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      #1;
      if (wv_b) wins_b++;
      chk("b_win", 32'(wv_b), 32'(i == 8));
      chk("b_done", 32'(done_b), 32'(i == 8));
      chk("b_col", 32'(col_b), 32'(i % 3));
      chk("b_row", 32'(row_b), 32'(i / 3));
    end
    @(negedge clk);
    chk("b_done_ready", 32'(ready_b), 32'd0);
    valid_b = 1'b0;
    @(posedge clk);
    #1;
    chk("b_idle_busy", 32'(busy_b), 32'd0);
    chk("b_win_total", 32'(wins_b), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
